// File: rtl/circuit_test_pkg.sv
// Shared types for the fault-run stimulus/response sequencer.
// Pattern packing: {x1,x2,x3} maps to bits {2,1,0} of each 3-bit pattern slice.
package circuit_test_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } state_t;

  localparam int PAT_W = 3;

  typedef struct packed {
    logic x1;
    logic x2;
    logic x3;
  } pat_t;

  function automatic int pat_lsb(input int idx);
    return PAT_W * idx;
  endfunction

endpackage

// File: rtl/stim_response_sequencer_if.sv
// Control and CUT-facing signals of the sequencer; slave is the sequencer side.
interface stim_response_sequencer_if #(
  parameter int NUM_PAT = 5
);
  localparam int CW = $clog2(NUM_PAT + 1);
  localparam int IW = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;

  logic          start;
  logic          z;
  logic          x1;
  logic          x2;
  logic          x3;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] err_count;
  logic [IW-1:0] first_fail_idx;

  modport master (
    output start, z,
    input  x1, x2, x3, busy, done, pass, err_count, first_fail_idx
  );

  modport slave (
    input  start, z,
    output x1, x2, x3, busy, done, pass, err_count, first_fail_idx
  );

endinterface

// File: rtl/hold_timer.sv
// Per-pattern hold counter; tc marks the last cycle of a pattern, i.e. the sample edge.
module hold_timer #(
  parameter  int HOLD_CYC = 2,
  localparam int HW       = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tc
);

  localparam logic [HW-1:0] LAST = HW'(HOLD_CYC - 1);

  logic [HW-1:0] hcnt;

  assign tc = run && (hcnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt <= '0;
    end else if (clear) begin
      hcnt <= '0;
    end else if (run) begin
      hcnt <= tc ? '0 : hcnt + HW'(1);
    end
  end

endmodule

// File: rtl/stim_response_sequencer.sv
// Drives a stored {x1,x2,x3} sequence into a reset-less CUT and scores its z output
// against golden bits, skipping the leading synchronising patterns.
//
// state | meaning
// IDLE  | after reset, waiting for start
// APPLY | patterns driven back-to-back, z sampled on each pattern's last cycle
// DONE  | results and last pattern held until start or reset
module stim_response_sequencer
  import circuit_test_pkg::*;
#(
  parameter int                       NUM_PAT  = 5,
  parameter int                       HOLD_CYC = 2,
  parameter int                       SYNC_PAT = 1,
  parameter logic [PAT_W*NUM_PAT-1:0] PATTERNS = 15'b110_101_111_110_010,
  parameter logic [NUM_PAT-1:0]       EXPECT   = 5'b00000
) (
  input logic                       clk,
  input logic                       reset,
  stim_response_sequencer_if.slave  bus
);

  localparam int CW = $clog2(NUM_PAT + 1);
  localparam int IW = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PAT - 1);
  localparam logic [IW:0]   SYNC_L   = (IW + 1)'(SYNC_PAT);

  state_t        state;
  logic [IW-1:0] pidx;
  pat_t          x_q;
  logic          busy_q, done_q, pass_q, fail_seen;
  logic [CW-1:0] err_q;
  logic [IW-1:0] ffi_q;

  pat_t          pat_rom [NUM_PAT];
  logic          tc, last, launch, mismatch;
  logic [IW-1:0] pidx_nxt;
  logic [CW-1:0] err_nxt;

  always_comb begin
    for (int i = 0; i < NUM_PAT; i++) begin
      pat_rom[i] = PATTERNS[pat_lsb(i) +: PAT_W];
    end
  end

  assign last     = (pidx == LAST_IDX);
  assign launch   = bus.start && (state != APPLY);
  assign pidx_nxt = last ? pidx : pidx + IW'(1);
  assign mismatch = tc && ({1'b0, pidx} >= SYNC_L) && (bus.z != EXPECT[pidx]);
  // Saturate so a fully failing run can never wrap back to a passing count.
  assign err_nxt  = (mismatch && (err_q != CW'(NUM_PAT))) ? err_q + CW'(1) : err_q;

  hold_timer #(.HOLD_CYC(HOLD_CYC)) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .clear (launch),
    .run   (state == APPLY),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pidx      <= '0;
      x_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      ffi_q     <= '0;
      fail_seen <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= APPLY;
            pidx      <= '0;
            x_q       <= pat_rom[0];
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            ffi_q     <= '0;
            fail_seen <= 1'b0;
          end
        end
        APPLY: begin
          if (tc) begin
            err_q <= err_nxt;
            if (mismatch && !fail_seen) begin
              ffi_q     <= pidx;
              fail_seen <= 1'b1;
            end
            if (!last) begin
              pidx <= pidx_nxt;
              x_q  <= pat_rom[pidx_nxt];
            end else begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (err_nxt == '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x1             = x_q.x1;
  assign bus.x2             = x_q.x2;
  assign bus.x3             = x_q.x3;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_stim_response_sequencer.sv
// Scoreboard bench: three sequencer configurations, randomized z streams and start
// pulses, expected responses derived from the pattern/golden tables cycle by cycle.
module tb_stim_response_sequencer;

  localparam int NP = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic z = 1'b0;
  int   dsel = 0;

  always #5 clk = ~clk;

  stim_response_sequencer_if #(.NUM_PAT(NP)) bus0 ();
  stim_response_sequencer_if #(.NUM_PAT(NP)) bus1 ();
  stim_response_sequencer_if #(.NUM_PAT(NP)) bus2 ();

  assign bus0.start = start && (dsel == 0);
  assign bus1.start = start && (dsel == 1);
  assign bus2.start = start && (dsel == 2);
  assign bus0.z = z;
  assign bus1.z = z;
  assign bus2.z = z;

  stim_response_sequencer #(.NUM_PAT(5), .HOLD_CYC(2), .SYNC_PAT(1),
    .PATTERNS(15'b110_101_111_110_010), .EXPECT(5'b11110))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  stim_response_sequencer #(.NUM_PAT(5), .HOLD_CYC(2), .SYNC_PAT(5),
    .PATTERNS(15'b110_101_111_110_010), .EXPECT(5'b11110))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  stim_response_sequencer #(.NUM_PAT(5), .HOLD_CYC(1), .SYNC_PAT(1),
    .PATTERNS(15'b110_101_111_110_010), .EXPECT(5'b11110))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int hold_of [3] = '{2, 2, 1};
  int sync_of [3] = '{1, 5, 1};

  // Pattern i as {x1,x2,x3} and golden z for pattern i.
  logic [2:0] pat_ref [NP] = '{3'b010, 3'b110, 3'b111, 3'b101, 3'b110};
  logic       exp_ref [NP] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  typedef struct packed {
    logic [2:0] x;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err;
    logic [2:0] ffi;
  } obs_t;

  typedef struct packed {
    logic [2:0] err;
    logic [2:0] ffi;
    logic       pass;
    logic [2:0] last_x;
    int         busy_len;
  } res_t;

  obs_t obs;
  always_comb begin
    obs = '0;
    case (dsel)
      0: obs = {bus0.x1, bus0.x2, bus0.x3, bus0.busy, bus0.done, bus0.pass,
                bus0.err_count, bus0.first_fail_idx};
      1: obs = {bus1.x1, bus1.x2, bus1.x3, bus1.busy, bus1.done, bus1.pass,
                bus1.err_count, bus1.first_fail_idx};
      default: obs = {bus2.x1, bus2.x2, bus2.x3, bus2.busy, bus2.done, bus2.pass,
                      bus2.err_count, bus2.first_fail_idx};
    endcase
  end

  logic [2:0] xq [$];
  res_t       resq [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t dut=%0d)", name, act, req, $time, dsel);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_state", int'(obs), 0);
  endtask

  // Monitor: pops expected x every busy cycle, expected result when done rises.
  initial begin : monitor
    int   busy_cnt;
    logic done_seen;
    logic have_res;
    res_t cur;
    busy_cnt  = 0;
    done_seen = 1'b0;
    have_res  = 1'b0;
    cur       = '0;
    wait (reset == 1'b0);
    forever begin
      @(negedge clk);
      if (obs.busy) begin
        check("done_low_while_busy", int'(obs.done), 0);
        if (xq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_busy: got busy=1, expected no pattern pending");
        end else begin
          check("x_pattern", int'(obs.x), int'(xq.pop_front()));
        end
        busy_cnt++;
        done_seen = 1'b0;
        have_res  = 1'b0;
      end else if (obs.done) begin
        if (!done_seen) begin
          if (resq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1, expected no result pending");
          end else begin
            cur = resq.pop_front();
            have_res = 1'b1;
            check("busy_len", busy_cnt, cur.busy_len);
          end
          done_seen = 1'b1;
        end
        if (have_res) begin
          check("err_count", int'(obs.err), int'(cur.err));
          check("first_fail_idx", int'(obs.ffi), int'(cur.ffi));
          check("pass", int'(obs.pass), int'(cur.pass));
          check("x_hold", int'(obs.x), int'(cur.last_x));
        end
        busy_cnt = 0;
      end else begin
        busy_cnt  = 0;
        done_seen = 1'b0;
        have_res  = 1'b0;
      end
    end
  end

  // mode: 0 z=x1, 1 z=x3, 2 z=~x1, 3 random z every cycle
  task automatic build_z(input int d, input int mode, output logic zarr [$]);
    int h;
    logic [2:0] p;
    h = hold_of[d];
    zarr = {};
    for (int k = 0; k < NP * h; k++) begin
      p = pat_ref[k / h];
      case (mode)
        0: zarr.push_back(p[2]);
        1: zarr.push_back(p[0]);
        2: zarr.push_back(~p[2]);
        default: zarr.push_back(1'($urandom_range(0, 1)));
      endcase
    end
  endtask

  task automatic run(input int d, input int mode, input bit extra);
    int   h, s, err, ffi;
    bit   found;
    logic zarr [$];
    res_t r;
    if (d != dsel) begin
      do_reset();
      dsel = d;
      #1;
    end
    h = hold_of[d];
    s = sync_of[d];
    build_z(d, mode, zarr);
    err = 0;
    ffi = 0;
    found = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (i >= s && zarr[(i + 1) * h - 1] != exp_ref[i]) begin
        if (err < NP) err++;
        if (!found) begin
          ffi = i;
          found = 1'b1;
        end
      end
    end
    for (int k = 0; k < NP * h; k++) xq.push_back(pat_ref[k / h]);
    r.err      = 3'(err);
    r.ffi      = 3'(ffi);
    r.pass     = (err == 0);
    r.last_x   = pat_ref[NP - 1];
    r.busy_len = NP * h;
    resq.push_back(r);

    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < NP * h; k++) begin
      z = zarr[k];
      start = extra && ($urandom_range(0, 3) == 0);
      step();
    end
    start = 1'b0;
    repeat ($urandom_range(1, 3)) step();
  endtask

  // Reset during the 5th APPLY cycle of dut0, then confirm everything cleared.
  task automatic run_abort();
    if (dsel != 0) begin
      do_reset();
      dsel = 0;
      #1;
    end
    for (int k = 0; k < 5; k++) xq.push_back(pat_ref[k / 2]);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      z = 1'($urandom_range(0, 1));
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_reset_state", int'(obs), 0);
    step();
    check("abort_idle_hold", int'(obs), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      dsel = d;
      #1;
      check("reset_state", int'(obs), 0);
    end
    dsel = 0;
    #1;

    run(0, 0, 1'b0);
    run(0, 1, 1'b0);
    run_abort();
    run(0, 0, 1'b0);
    run(0, 1, 1'b1);
    run(0, 0, 1'b1);
    run(1, 2, 1'b0);
    run(1, 3, 1'b1);
    run(2, 0, 1'b0);
    run(2, 1, 1'b1);
    run(2, 3, 1'b0);
    for (int n = 0; n < 16; n++) begin
      run($urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) step();
    check("x_queue_drained", xq.size(), 0);
    check("result_queue_drained", resq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stim_response_sequencer.md
Name: stim_response_sequencer

Overview:
On-chip stimulus and response block for the sequential circuits under fault analysis, which have no set or reset.
- Drives a stored sequence of {x1,x2,x3} input patterns into the circuit under test (CUT), holding each pattern for a fixed number of clocks.
- Samples the CUT output z once per pattern and compares it against a stored golden bit.
- Skips a leading synchronising prefix, because the CUT's power-up state is unknown.
- Reports mismatch count, first failing pattern index and pass/fail. This replaces the hand-written stimulus bench for silicon and FPGA fault runs.

Parameters:
- NUM_PAT, 5: number of patterns in the sequence (must be ≥1).
- HOLD_CYC, 2: clocks each pattern is held (must be ≥1).
- SYNC_PAT, 1: leading patterns applied but not compared (0..NUM_PAT).
- PATTERNS, 15'b110_101_111_110_010: pattern i is PATTERNS[3*i +: 3], packed as {x1,x2,x3}.
- EXPECT, 5'b00000: EXPECT[i] is the golden z for pattern i.

Ports:
- clk, input, 1: rising-edge clock shared with the CUT.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle request to run the sequence.
- z, input, 1: CUT output.
- x1, output, 1: CUT stimulus bit (PATTERNS bit 2 of each pattern).
- x2, output, 1: CUT stimulus bit (PATTERNS bit 1 of each pattern).
- x3, output, 1: CUT stimulus bit (PATTERNS bit 0 of each pattern).
- busy, output, 1: high while patterns are being applied.
- done, output, 1: high from sequence completion until the next start or reset.
- pass, output, 1: valid while done=1; 1 iff err_count==0.
- err_count, output, CW=$clog2(NUM_PAT+1): compared mismatches.
- first_fail_idx, output, IW=max(1,$clog2(NUM_PAT)): index of the first mismatch; 0 if none.

Behaviour:
- Reset is synchronous, active-high and wins over everything, including mid-run. It forces the following values:
  - state=IDLE
  - x1/x2/x3=0
  - busy=0, done=0, pass=0
  - err_count=0, first_fail_idx=0
  - pattern index pidx=0, hold counter hcnt=0
- State machine:
  - IDLE: start=1 → APPLY. On the same edge: pidx=0, hcnt=0, {x1,x2,x3}=pattern 0, busy=1, err_count=0, first_fail_idx=0, fail flag cleared.
  - APPLY: pattern pidx is driven for exactly HOLD_CYC cycles, and hcnt increments every cycle.
    - On the edge where hcnt==HOLD_CYC-1, z is sampled. If pidx ≥ SYNC_PAT and z != EXPECT[pidx]:
      - err_count increments, saturating at NUM_PAT.
      - If this is the first mismatch, first_fail_idx=pidx.
    - On that same edge, if pidx < NUM_PAT-1: pidx increments, hcnt=0, and the next pattern is driven from the following cycle.
    - Otherwise → DONE: busy=0, done=1, and pass=(final err_count==0), including any mismatch sampled on this edge.
  - DONE: outputs hold, and {x1,x2,x3} keeps the last pattern. start=1 → restart exactly as from IDLE (done drops on the same edge).
- start is ignored while in APPLY.
- Latency: busy is high for exactly NUM_PAT*HOLD_CYC cycles after the start edge. done rises on the edge that ends the last pattern.
- Patterns are back-to-back: there are no gap cycles between patterns.
- z is sampled synchronously; the CUT is in the same clock domain and z must be stable before the sample edge.
- HOLD_CYC=1: every APPLY cycle is a sample cycle.
- SYNC_PAT=NUM_PAT: nothing is compared, and pass=1.

Decomposition:
- Shared package circuit_test_pkg contains:
  - state enum {IDLE, APPLY, DONE}
  - localparam PAT_W=3
  - the pattern packing rule
- One natural sub-module: hold_timer (hcnt with a terminal-count pulse). The rest stays flat.

Test Plan:
1. Default patterns, EXPECT=5'b11110, stub CUT z=x1, start pulse → busy for 10 cycles, then done=1, pass=1, err_count=0.
2. Same setup with stub z=x3 (x3 sequence 0,0,1,1,0) → mismatches at indices 1 and 4; err_count=2, first_fail_idx=1, pass=0.
3. Waveform check of run 1 → x sequence 010,110,111,101,110 with each pattern exactly 2 cycles; 5 sample edges; done on the 10th edge after start.
4. Assert reset at the 5th APPLY cycle → next cycle is IDLE with all outputs 0; a new start then gives the same result as run 1.
5. start pulses during APPLY are ignored (run length unchanged). start in DONE restarts with counters cleared and done low for 10 cycles.
6. SYNC_PAT=5 with stub z=~x1 → err_count=0, pass=1. HOLD_CYC=1 → busy lasts 5 cycles and sampling is still correct.
